mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_pkg.sv | 29 ++
 rtl/mem_arbiter_arb_pick.sv | 35 +++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings for the memory port arbiter
// Contents:
//   RW_NONE/RW_READ/RW_WRITE  rw_flag encodings (2'b11 is never a request)
//   arb_state_e               arbiter FSM states
//   grant_e                   which requester owns the memory port
//   is_req()                  true for a valid read or write request
package mem_arbiter_pkg;

  localparam logic [1:0] RW_NONE  = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b01;
  localparam logic [1:0] RW_WRITE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

  function automatic logic is_req(input logic [1:0] rw);
    return (rw == RW_READ) || (rw == RW_WRITE);
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// rtl/mem_arbiter_arb_pick.sv - combinational grant select between I and D requesters
// Build option: ARB_ROUND_ROBIN_EN (collisions go to the side not granted last;
// otherwise D always wins a collision).
// Ports:
//   i_req, d_req  in   valid request present on each side
//   last_grant    in   side granted most recently (round-robin build only)
//   any_req       out  at least one side is requesting
//   pick          out  side to grant this cycle (meaningful when any_req=1)
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  grant_e last_grant,
`endif
  output logic   any_req,
  output grant_e pick
);

  always_comb begin
    any_req = i_req | d_req;
    pick    = GRANT_I;
    if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      pick = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
`else
      pick = GRANT_D;
`endif
    end else if (d_req) begin
      pick = GRANT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between I-cache and D-cache fill paths
// Build option: ARB_ROUND_ROBIN_EN selects round-robin collision handling (default: D priority).
// Ports:
//   clk, rst                              clock; asynchronous active-low reset
//   i_rw_flag/i_addr/i_wdata/i_mask       I-side request (01 read, 10 write)
//   i_rdata/i_busy/i_done                 I-side read data, pending flag, completion pulse
//   d_*                                   D-side, same meaning as i_*
//   mem_rw_flag/mem_addr/mem_wdata/mem_mask  command to memory (registered)
//   mem_rdata/mem_busy/mem_done           memory response / back-pressure / completion
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MASK_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        i_rw_flag,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [MASK_W-1:0] i_mask,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_busy,
  output logic              i_done,
  input  logic [1:0]        d_rw_flag,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [MASK_W-1:0] d_mask,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_busy,
  output logic              d_done,
  output logic [1:0]        mem_rw_flag,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_mask,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_busy,
  input  logic              mem_done
);

  arb_state_e        state_q, state_d;
  grant_e            grant_q;
  grant_e            pick;
  logic              any_req;
  logic              i_req, d_req;
  logic              load, capture;
  logic              in_flight;
  logic [DATA_W-1:0] rdata_q;

  assign i_req = is_req(i_rw_flag);
  assign d_req = is_req(d_rw_flag);

`ifdef ARB_ROUND_ROBIN_EN
  grant_e last_grant_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= GRANT_I;
    end else if (load) begin
      last_grant_q <= pick;
    end
  end
`endif

  arb_pick u_pick (
    .i_req     (i_req),
    .d_req     (d_req),
`ifdef ARB_ROUND_ROBIN_EN
    .last_grant(last_grant_q),
`endif
    .any_req   (any_req),
    .pick      (pick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Requests are only looked at in IDLE, so a requester still holding its
  // flags during DONE is not granted a second time.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          load    = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!mem_busy) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_done) begin
          capture = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q     <= GRANT_I;
      mem_rw_flag <= RW_NONE;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_mask    <= '0;
      rdata_q     <= '0;
    end else begin
      if (load) begin
        grant_q <= pick;
        if (pick == GRANT_D) begin
          mem_rw_flag <= d_rw_flag;
          mem_addr    <= d_addr;
          mem_wdata   <= d_wdata;
          mem_mask    <= d_mask;
        end else begin
          mem_rw_flag <= i_rw_flag;
          mem_addr    <= i_addr;
          mem_wdata   <= i_wdata;
          mem_mask    <= i_mask;
        end
      end
      if (capture) begin
        rdata_q     <= mem_rdata;
        mem_rw_flag <= RW_NONE;
      end
    end
  end

  assign in_flight = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign i_done    = (state_q == ST_DONE) && (grant_q == GRANT_I);
  assign d_done    = (state_q == ST_DONE) && (grant_q == GRANT_D);
  assign i_rdata   = i_done ? rdata_q : '0;
  assign d_rdata   = d_done ? rdata_q : '0;

  // A granted side stays busy even if it drops its flags mid-transaction;
  // reset forces busy low regardless of what the requesters are driving.
  assign i_busy = rst && !i_done && (i_req || (in_flight && grant_q == GRANT_I));
  assign d_busy = rst && !d_done && (d_req || (in_flight && grant_q == GRANT_D));

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam logic [1:0] NO = 2'b00;
  localparam logic [1:0] RD = 2'b01;
  localparam logic [1:0] WR = 2'b10;
  localparam logic [1:0] XX = 2'b11;

  typedef struct packed {
    logic [1:0]  flag;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } req_t;

  typedef struct {
    req_t ir;
    req_t dr;
    int   busy;
    int   lat;
    int   fx1, fx2, rr1, rr2;   // expected done order: 0=I 1=D 2=none
  } row_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  i_rw_flag, d_rw_flag, mem_rw_flag;
  logic [31:0] i_addr, i_wdata, i_rdata, d_addr, d_wdata, d_rdata;
  logic [3:0]  i_mask, d_mask, mem_mask;
  logic        i_busy, i_done, d_busy, d_done;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_busy, mem_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_rw_flag(i_rw_flag), .i_addr(i_addr), .i_wdata(i_wdata), .i_mask(i_mask),
    .i_rdata(i_rdata), .i_busy(i_busy), .i_done(i_done),
    .d_rw_flag(d_rw_flag), .d_addr(d_addr), .d_wdata(d_wdata), .d_mask(d_mask),
    .d_rdata(d_rdata), .d_busy(d_busy), .d_done(d_done),
    .mem_rw_flag(mem_rw_flag), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mask(mem_mask), .mem_rdata(mem_rdata), .mem_busy(mem_busy), .mem_done(mem_done)
  );

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic req_t mk(input logic [1:0] f, input logic [31:0] a,
                              input logic [31:0] w, input logic [3:0] m);
    req_t r;
    r.flag = f; r.addr = a; r.wdata = w; r.mask = m;
    return r;
  endfunction

  function automatic row_t mkrow(input req_t ir, input req_t dr, input int busy, input int lat,
                                 input int fx1, input int fx2, input int rr1, input int rr2);
    row_t r;
    r.ir = ir; r.dr = dr; r.busy = busy; r.lat = lat;
    r.fx1 = fx1; r.fx2 = fx2; r.rr1 = rr1; r.rr2 = rr2;
    return r;
  endfunction

  function automatic bit is_rq(input logic [1:0] f);
    return (f == RD) || (f == WR);
  endfunction

  // Memory contents seen by reads: a fixed value at 0x100, a hash elsewhere.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // ---------------- memory responder model ----------------
  int          lat_cfg = 1;
  int          busy_cycles = 0;
  int          stray_cnt = 0;
  int          stray_seen = 0;
  bit          pend = 1'b0;
  req_t        acc_q[$];

  initial begin
    bit          acc, fin;
    int          cnt, bcnt;
    logic [31:0] resp;
    cnt = 0; bcnt = 0; resp = '0;
    mem_busy = 1'b0; mem_done = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      acc = rst && (mem_rw_flag != NO) && !mem_busy && !pend;
      fin = mem_done;
      if (acc) begin
        acc_q.push_back(mk(mem_rw_flag, mem_addr, mem_wdata, mem_mask));
        resp = (mem_rw_flag == RD) ? mem_fn(mem_addr) : 32'h0;
      end
      @(posedge clk);
      #1;
      if (!rst) begin
        pend = 1'b0; mem_done = 1'b0; mem_rdata = '0; mem_busy = 1'b0; bcnt = 0;
        acc_q.delete();
      end else begin
        if (fin) begin
          mem_done = 1'b0; mem_rdata = '0; pend = 1'b0;
        end
        if (acc) begin
          pend = 1'b1; cnt = lat_cfg; bcnt = 0;
        end else if (pend && !fin) begin
          cnt--;
          if (cnt <= 0) begin
            mem_done = 1'b1; mem_rdata = resp;
          end
        end
        if (stray_cnt != stray_seen) begin
          stray_seen = stray_cnt;
          mem_done = 1'b1;
        end
        mem_busy = (mem_rw_flag != NO) && !pend && (bcnt < busy_cycles);
        if (mem_busy) bcnt++;
      end
    end
  end

  // ---------------- always-on output rules ----------------
  bit prev_i = 1'b0;
  bit prev_d = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (i_done) chk("i_done_width", prev_i, 0);
      if (d_done) chk("d_done_width", prev_d, 0);
      if (i_done) chk("done_exclusive", d_done, 0);
      if (!i_done) chk("i_rdata_idle", i_rdata, 0);
      if (!d_done) chk("d_rdata_idle", d_rdata, 0);
      prev_i = i_done;
      prev_d = d_done;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  // A completion must match the oldest command memory accepted and return its data.
  task automatic verify_done(input string tag, input req_t r, input logic [31:0] rd);
    req_t a;
    if (acc_q.size() == 0) begin
      chk({tag, "_accepted"}, 0, 1);
    end else begin
      a = acc_q.pop_front();
      chk({tag, "_cmd"}, a, r);
    end
    chk({tag, "_rdata"}, rd, (r.flag == RD) ? mem_fn(r.addr) : 32'h0);
  endtask

  task automatic drive_idle();
    i_rw_flag = NO; i_addr = '0; i_wdata = '0; i_mask = '0;
    d_rw_flag = NO; d_addr = '0; d_wdata = '0; d_mask = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem"}, {mem_rw_flag, mem_addr, mem_wdata, mem_mask}, 0);
    chk({tag, "_ctl"}, {i_busy, d_busy, i_done, d_done}, 0);
    chk({tag, "_rdata"}, {i_rdata, d_rdata}, 0);
  endtask

  task automatic run_pair(input int idx, input row_t r, output int first, output int second);
    int ord[2];
    int n, need;
    bit ia, da, idn, ddn;
    string t;
    t = $sformatf("row%0d", idx);
    ia = is_rq(r.ir.flag);
    da = is_rq(r.dr.flag);
    need = int'(ia) + int'(da);
    ord[0] = 2; ord[1] = 2; n = 0;
    lat_cfg = r.lat; busy_cycles = r.busy;
    @(posedge clk); #1;
    i_rw_flag = r.ir.flag; i_addr = r.ir.addr; i_wdata = r.ir.wdata; i_mask = r.ir.mask;
    d_rw_flag = r.dr.flag; d_addr = r.dr.addr; d_wdata = r.dr.wdata; d_mask = r.dr.mask;
    for (int c = 0; c < 80 && n < need; c++) begin
      @(negedge clk);
      idn = i_done; ddn = d_done;
      if (i_done) begin
        if (n < 2) ord[n] = 0;
        n++;
        verify_done({t, "_i"}, r.ir, i_rdata);
        chk({t, "_i_busy_at_done"}, i_busy, 0);
      end else if (ia) chk({t, "_i_busy"}, i_busy, 1);
      if (d_done) begin
        if (n < 2) ord[n] = 1;
        n++;
        verify_done({t, "_d"}, r.dr, d_rdata);
        chk({t, "_d_busy_at_done"}, d_busy, 0);
      end else if (da) chk({t, "_d_busy"}, d_busy, 1);
      @(posedge clk); #1;
      if (idn) begin i_rw_flag = NO; ia = 1'b0; end
      if (ddn) begin d_rw_flag = NO; da = 1'b0; end
    end
    chk({t, "_completed"}, n, need);
    repeat (4) begin
      @(negedge clk);
      chk({t, "_tail_done"}, {i_done, d_done}, 0);
      chk({t, "_tail_busy"}, {i_busy, d_busy}, 0);
      chk({t, "_tail_mem"}, mem_rw_flag, NO);
    end
    @(posedge clk); #1;
    drive_idle();
    first = ord[0];
    second = ord[1];
  endtask

  row_t rows[7];

  initial begin
    int   f1, f2, e1, e2, w, ic, dc, igap, dgap;
    int   seq[$];
    bit   idn, ddn, iact, dact;
    req_t ir, dr;

    rows[0] = mkrow(mk(RD, 32'h110, 32'h0, 4'h0), mk(RD, 32'h210, 32'h0, 4'h0), 3, 2, 1, 0, 1, 0);
    rows[1] = mkrow(mk(RD, 32'h100, 32'h0, 4'h0), mk(NO, 32'h0, 32'h0, 4'h0), 0, 4, 0, 2, 0, 2);
    rows[2] = mkrow(mk(NO, 32'h0, 32'h0, 4'h0), mk(WR, 32'h200, 32'h12345678, 4'b0011), 0, 3, 1, 2, 1, 2);
    rows[3] = mkrow(mk(RD, 32'h130, 32'h0, 4'h0), mk(WR, 32'h230, 32'hCAFEF00D, 4'hF), 1, 2, 1, 0, 0, 1);
    rows[4] = mkrow(mk(XX, 32'h140, 32'h0, 4'h0), mk(NO, 32'h0, 32'h0, 4'h0), 0, 1, 2, 2, 2, 2);
    rows[5] = mkrow(mk(WR, 32'h150, 32'h11112222, 4'b1000), mk(XX, 32'h250, 32'h0, 4'h0), 0, 1, 0, 2, 0, 2);
    rows[6] = mkrow(mk(WR, 32'h160, 32'h33334444, 4'b0101), mk(RD, 32'h260, 32'h0, 4'h0), 2, 3, 1, 0, 1, 0);

    // Reset with a request already on the I side: outputs must stay quiet.
    rst = 1'b0;
    drive_idle();
    i_rw_flag = RD;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    i_rw_flag = NO;

    // Reset arriving while a read waits on slow memory.
    lat_cfg = 30; busy_cycles = 0;
    @(posedge clk); #1;
    i_rw_flag = RD; i_addr = 32'h40;
    w = 0;
    while (!pend && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("midwait_accepted", pend, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("midwait_reset");
    @(posedge clk); #1;
    i_rw_flag = NO;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("post_reset_done", {i_done, d_done}, 0);
      chk("post_reset_mem", mem_rw_flag, NO);
    end

    // Table of single requests and collisions, starting from a fresh grant history.
    for (int k = 0; k < 7; k++) begin
      run_pair(k, rows[k], f1, f2);
`ifdef ARB_ROUND_ROBIN_EN
      e1 = rows[k].rr1; e2 = rows[k].rr2;
`else
      e1 = rows[k].fx1; e2 = rows[k].fx2;
`endif
      chk($sformatf("row%0d_first", k), f1, e1);
      chk($sformatf("row%0d_second", k), f2, e2);
    end

    // Stray memory completion while idle must not produce a done.
    @(posedge clk); #1;
    stray_cnt++;
    repeat (4) begin
      @(negedge clk);
      chk("stray_done", {i_done, d_done}, 0);
      chk("stray_mem", mem_rw_flag, NO);
    end

    // Both sides re-request immediately after every completion, ten each.
    lat_cfg = 1; busy_cycles = 0; ic = 0; dc = 0;
    @(posedge clk); #1;
    i_rw_flag = RD; i_addr = 32'h300;
    d_rw_flag = RD; d_addr = 32'h400;
    for (int c = 0; c < 600 && (ic < 10 || dc < 10); c++) begin
      @(negedge clk);
      idn = i_done; ddn = d_done;
      if (i_done) begin
        seq.push_back(0);
        verify_done("b2b_i", mk(i_rw_flag, i_addr, i_wdata, i_mask), i_rdata);
        ic++;
      end
      if (d_done) begin
        seq.push_back(1);
        verify_done("b2b_d", mk(d_rw_flag, d_addr, d_wdata, d_mask), d_rdata);
        dc++;
      end
      @(posedge clk); #1;
      if (idn) begin
        if (ic < 10) i_addr = 32'h300 + 32'(ic * 4);
        else i_rw_flag = NO;
      end
      if (ddn) begin
        if (dc < 10) d_addr = 32'h400 + 32'(dc * 4);
        else d_rw_flag = NO;
      end
    end
    chk("b2b_count", seq.size(), 20);
    for (int k = 0; k < 20; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      e1 = (k % 2 == 0) ? 1 : 0;
`else
      e1 = (k < 10) ? 1 : 0;
`endif
      f1 = (k < seq.size()) ? seq[k] : 2;
      chk($sformatf("b2b_order%0d", k), f1, e1);
    end
    @(posedge clk); #1;
    drive_idle();

    // Random traffic: every completion must match the command memory saw.
    iact = 1'b0; dact = 1'b0; igap = 0; dgap = 0;
    ir = mk(NO, 0, 0, 0); dr = mk(NO, 0, 0, 0);
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      idn = i_done; ddn = d_done;
      if (i_done) verify_done("rnd_i", ir, i_rdata);
      else if (iact) chk("rnd_i_busy", i_busy, 1);
      if (d_done) verify_done("rnd_d", dr, d_rdata);
      else if (dact) chk("rnd_d_busy", d_busy, 1);
      if (c >= 1200 && !iact && !dact) break;
      @(posedge clk); #1;
      lat_cfg = $urandom_range(1, 4);
      busy_cycles = $urandom_range(0, 2);
      if (idn) begin
        iact = 1'b0; i_rw_flag = NO; igap = $urandom_range(0, 3);
      end else if (!iact && c < 1200) begin
        if (igap > 0) igap--;
        else begin
          ir = mk(($urandom_range(0, 1) == 1) ? WR : RD, $urandom & 32'hFFFF_FFFC,
                  $urandom, 4'($urandom_range(0, 15)));
          i_rw_flag = ir.flag; i_addr = ir.addr; i_wdata = ir.wdata; i_mask = ir.mask;
          iact = 1'b1;
        end
      end
      if (ddn) begin
        dact = 1'b0; d_rw_flag = NO; dgap = $urandom_range(0, 3);
      end else if (!dact && c < 1200) begin
        if (dgap > 0) dgap--;
        else begin
          dr = mk(($urandom_range(0, 1) == 1) ? WR : RD, $urandom & 32'hFFFF_FFFC,
                  $urandom, 4'($urandom_range(0, 15)));
          d_rw_flag = dr.flag; d_addr = dr.addr; d_wdata = dr.wdata; d_mask = dr.mask;
          dact = 1'b1;
        end
      end
    end
    chk("rnd_drained", {iact, dact}, 0);
    chk("rnd_queue_empty", acc_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
